// File: rtl/sign_encoder.sv
// sign_encoder: accepts a 4-bit sign code and presents it as a five-finger
// pattern for HOLD_CYCLES cycles, pulsing sign_done on the last hold cycle.
// Illegal codes (9..15) pulse sign_err and leave the block idle.
// Optional feature: define SIGN_GAP_EN to add a GAP_CYCLES rest period
// (all fingers lowered) after every completed presentation.
module sign_encoder #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned GAP_CYCLES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sign_value,
   input  logic       sign_valid,
   output logic       sign_ready,
   input  logic       sign_abort,
   output logic       thumb_cmd,
   output logic       index_cmd,
   output logic       middle_cmd,
   output logic       ring_cmd,
   output logic       pinky_cmd,
   output logic       sign_done,
   output logic       sign_err
);

`ifdef SIGN_GAP_EN
   typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
`else
   typedef enum logic [1:0] {IDLE, HOLD} state_t;
`endif

   localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);
   localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [4:0]  pat_q, pat_d;   // {pinky, ring, middle, index, thumb}
   logic        err_q, err_d;
   logic [4:0]  fingers;

   // Code-to-finger table; only called for legal codes 0..8.
   function automatic logic [4:0] code_to_pat(input logic [3:0] code);
      case (code)
         4'd1:    code_to_pat = 5'b00010;
         4'd2:    code_to_pat = 5'b00110;
         4'd3:    code_to_pat = 5'b00111;
         4'd4:    code_to_pat = 5'b11110;
         4'd5:    code_to_pat = 5'b11111;
         4'd6:    code_to_pat = 5'b10001;
         4'd7:    code_to_pat = 5'b10011;
         4'd8:    code_to_pat = 5'b00011;
         default: code_to_pat = 5'b00000;
      endcase
   endfunction

   // State, counter, latched pattern and error pulse registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pat_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pat_q   <= pat_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic: accept in IDLE, count down HOLD (and GAP), abort wins.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pat_d   = pat_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            // sign_abort is deliberately ignored here
            if (sign_valid) begin
               if (sign_value <= 4'd8) begin
                  state_d = HOLD;
                  cnt_d   = HOLD_LOAD;
                  pat_d   = code_to_pat(sign_value);
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         HOLD: begin
            if (sign_abort) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == 16'd0) begin
`ifdef SIGN_GAP_EN
               state_d = GAP;
`else
               state_d = IDLE;
`endif
               // counter content is a don't-care once back in IDLE
               cnt_d = GAP_LOAD;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
`ifdef SIGN_GAP_EN
         GAP: begin
            if (sign_abort || cnt_q == 16'd0) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
`endif
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Fingers are only raised in HOLD, so reset lowers them without a clock.
   assign fingers    = (state_q == HOLD) ? pat_q : 5'b00000;
   assign thumb_cmd  = fingers[0];
   assign index_cmd  = fingers[1];
   assign middle_cmd = fingers[2];
   assign ring_cmd   = fingers[3];
   assign pinky_cmd  = fingers[4];

   assign sign_ready = (state_q == IDLE);
   assign sign_done  = (state_q == HOLD) && (cnt_q == 16'd0) && !sign_abort;
   assign sign_err   = err_q;

endmodule

// File: tb/tb_sign_encoder.sv
// Bench for sign_encoder: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a timeline model.
module tb_sign_encoder;
   localparam int H  = 4;
   localparam int GP = 2;
`ifdef SIGN_GAP_EN
   localparam int G = GP;
`else
   localparam int G = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] sign_value = 4'd0;
   logic       sign_valid = 1'b0;
   logic       sign_abort = 1'b0;
   logic       sign_ready, sign_done, sign_err;
   logic       thumb_cmd, index_cmd, middle_cmd, ring_cmd, pinky_cmd;
   logic [4:0] fingers;

   int checks   = 0;
   int failures = 0;

   sign_encoder #(.HOLD_CYCLES(H), .GAP_CYCLES(GP)) dut (
      .clk(clk), .rst(rst),
      .sign_value(sign_value), .sign_valid(sign_valid), .sign_ready(sign_ready),
      .sign_abort(sign_abort),
      .thumb_cmd(thumb_cmd), .index_cmd(index_cmd), .middle_cmd(middle_cmd),
      .ring_cmd(ring_cmd), .pinky_cmd(pinky_cmd),
      .sign_done(sign_done), .sign_err(sign_err)
   );

   assign fingers = {pinky_cmd, ring_cmd, middle_cmd, index_cmd, thumb_cmd};

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- timeline model ----------------
   // An accept at cycle t puts the pattern on cycles t+1..t+H, then G rest
   // cycles; the block is idle again from t+1+H+G. An abort at cycle t ends
   // everything at t+1.
   logic [4:0] ptab [0:8] = '{5'b00000, 5'b00010, 5'b00110, 5'b00111, 5'b11110,
                              5'b11111, 5'b10001, 5'b10011, 5'b00011};
   int         t = 0, hold_end = 0, busy_end = 0, err_at = -1, done_seen = 0;
   logic [4:0] m_pat = 5'b0;
   logic [4:0] exp_f;
   logic       exp_done;

   always @(negedge clk) begin
      #2;
      if (!rst) begin
         hold_end = t; busy_end = t; err_at = -1;
         chk("rst_fingers", 32'(fingers), 32'd0);
         chk("rst_ready",   32'(sign_ready), 32'd1);
         chk("rst_done",    32'(sign_done), 32'd0);
         chk("rst_err",     32'(sign_err), 32'd0);
      end else begin
         exp_f    = (t < hold_end) ? m_pat : 5'b0;
         exp_done = (t == hold_end - 1) && !sign_abort;
         chk("fingers", 32'(fingers),   32'(exp_f));
         chk("ready",   32'(sign_ready), 32'(t >= busy_end));
         chk("done",    32'(sign_done),  32'(exp_done));
         chk("err",     32'(sign_err),   32'(t == err_at));
         if (sign_done === 1'b1) done_seen++;
         if (t < busy_end) begin
            if (sign_abort) begin
               busy_end = t + 1;
               if (hold_end > t + 1) hold_end = t + 1;
            end
         end else if (sign_valid) begin
            if (sign_value <= 4'd8) begin
               m_pat    = ptab[sign_value];
               hold_end = t + 1 + H;
               busy_end = hold_end + G;
            end else begin
               err_at = t + 1;
            end
         end
      end
      t++;
   end

   // ---------------- stimulus ----------------
   int   d0, idx;
   logic took;

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #3 chk("ready_after_reset", 32'(sign_ready), 32'd1);

      // code 4 timeline with literal values
      @(negedge clk); sign_value = 4'd4; sign_valid = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk); sign_valid = 1'b0;
         #3;
         chk("c4_fingers", 32'(fingers), 32'b11110);
         chk("c4_done", 32'(sign_done), 32'(k == 4));
      end
      @(negedge clk); #3;
      chk("c4_after_fingers", 32'(fingers), 32'd0);
      chk("c4_after_ready", 32'(sign_ready), 32'(G == 0));
`ifdef SIGN_GAP_EN
      @(negedge clk); #3 chk("c4_gap2_ready", 32'(sign_ready), 32'd0);
      chk("c4_gap2_fingers", 32'(fingers), 32'd0);
      @(negedge clk); #3 chk("c4_ready_again", 32'(sign_ready), 32'd1);
`endif

      // illegal code 11
      @(negedge clk); sign_value = 4'd11; sign_valid = 1'b1;
      #3 chk("c11_ready", 32'(sign_ready), 32'd1);
      @(negedge clk); sign_valid = 1'b0;
      #3 chk("c11_err", 32'(sign_err), 32'd1);
      chk("c11_fingers", 32'(fingers), 32'd0);
      chk("c11_ready2", 32'(sign_ready), 32'd1);
      @(negedge clk); #3 chk("c11_err_gone", 32'(sign_err), 32'd0);

      // code 5, abort on second hold cycle
      @(negedge clk); sign_value = 4'd5; sign_valid = 1'b1;
      @(negedge clk); sign_valid = 1'b0;
      #3 chk("c5_hold1", 32'(fingers), 32'b11111);
      @(negedge clk); sign_abort = 1'b1;
      #3 chk("c5_hold2", 32'(fingers), 32'b11111);
      chk("c5_no_done", 32'(sign_done), 32'd0);
      @(negedge clk); sign_abort = 1'b0;
      #3 chk("c5_aborted_fingers", 32'(fingers), 32'd0);
      chk("c5_aborted_ready", 32'(sign_ready), 32'd1);

      // codes 0..8 back to back, valid held high
      d0 = done_seen; idx = 0;
      @(negedge clk); sign_valid = 1'b1; sign_value = 4'd0;
      #1 took = sign_ready;
      for (int n = 0; n < 300 && idx < 9; n++) begin
         @(negedge clk);
         if (took) begin
            idx++;
            sign_value = 4'(idx);
            if (idx == 9) sign_valid = 1'b0;
         end
         #1 took = sign_ready;
      end
      chk("b2b_progress", 32'(idx), 32'd9);
      repeat (20) @(negedge clk);
      chk("b2b_done_count", 32'(done_seen - d0), 32'd9);

      // asynchronous reset in the middle of code 7
      @(negedge clk); sign_value = 4'd7; sign_valid = 1'b1;
      @(negedge clk); sign_valid = 1'b0;
      #3 chk("c7_hold1", 32'(fingers), 32'b10011);
      @(posedge clk); #2 rst = 1'b0;
      #1 chk("c7_async_fingers", 32'(fingers), 32'd0);
      chk("c7_async_done", 32'(sign_done), 32'd0);
      @(negedge clk);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk); #3 chk("c7_ready_after_release", 32'(sign_ready), 32'd1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         sign_valid = ($urandom_range(0, 1) == 1);
         sign_value = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 8))
                                                  : 4'($urandom_range(9, 15));
         sign_abort = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 299) == 0) begin
            @(posedge clk); #2 rst = 1'b0;
            #1 chk("rand_async_fingers", 32'(fingers), 32'd0);
            @(negedge clk);
            @(posedge clk); #1 rst = 1'b1;
         end
      end
      @(negedge clk); sign_valid = 1'b0; sign_abort = 1'b0;
      repeat (5) @(negedge clk);
      #4;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
